// File: rtl/fnd_scan_driver_if.sv
// Load/busy handshake between the calculator datapath and the FND scan driver.
interface fnd_scan_driver_if #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] fnd_serial;
    logic [DIGITS-1:0] dp_mask;
    logic              load;
    logic              busy;

    modport master (output fnd_serial, output dp_mask, output load, input busy);
    modport slave  (input fnd_serial, input dp_mask, input load, output busy);
endinterface

// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment driver: signed binary -> decimal via sequential double-dabble,
// atomic digit-buffer commit, and a free-running PWM/blink digit scan.
module fnd_scan_driver #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_LOG2   = 10,
    parameter int unsigned BRIGHT_W   = 3,
    parameter int unsigned BLINK_LOG2 = 6
) (
    input  logic                fnd_clk,
    input  logic                rst,
    fnd_scan_driver_if.slave    bus,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                blink,
    output logic [DIGITS-1:0]   fnd_s,
    output logic [7:0]          fnd_d
);
    localparam int unsigned BCD_N = (DATA_W + 2) / 3 + 1;
    localparam int unsigned BCD_W = 4 * BCD_N;
    localparam int unsigned NDIG  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int unsigned KW    = $clog2(DIGITS);
    localparam int unsigned CW    = $clog2(DATA_W);
    localparam int unsigned FW    = BLINK_LOG2 + 1;
    localparam logic [KW-1:0] KLast = KW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

    state_e                   state_q, state_d;
    logic                     accept;
    logic [DATA_W-1:0]        mag_q, mag_in;
    logic                     neg_q;
    logic [DIGITS-1:0]        dp_q;
    logic [BCD_W-1:0]         bcd_q, bcd_adj, bcd_next;
    logic [CW-1:0]            cnt_q;
    logic [DIGITS-1:0][7:0]   disp_q, disp_new;
    logic [DIV_LOG2-1:0]      p_q;
    logic [KW-1:0]            k_q;
    logic [FW-1:0]            frame_q;
    logic                     p_wrap, k_wrap, lit;
    logic [DIGITS-1:0]        fnd_s_q;
    logic [7:0]               fnd_d_q;
    logic [3:0]               dig [NDIG];
    int                       usable, msd;
    logic                     ovf;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 8'h3F;
            4'd1: seg7 = 8'h06;
            4'd2: seg7 = 8'h5B;
            4'd3: seg7 = 8'h4F;
            4'd4: seg7 = 8'h66;
            4'd5: seg7 = 8'h6D;
            4'd6: seg7 = 8'h7D;
            4'd7: seg7 = 8'h07;
            4'd8: seg7 = 8'h7F;
            4'd9: seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // A load is taken in IDLE and also on the COMMIT edge, so back-to-back loads never stall.
    assign accept = bus.load && (state_q == StIdle || state_q == StCommit);
    assign mag_in = bus.fnd_serial[DATA_W-1] ? (~bus.fnd_serial + DATA_W'(1)) : bus.fnd_serial;

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StConv;
            StConv:   if (cnt_q == CW'(DATA_W - 1)) state_d = StCommit;
            StCommit: state_d = accept ? StConv : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != StIdle);
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int j = 0; j < int'(BCD_N); j++) begin
            if (bcd_q[j*4 +: 4] >= 4'd5) bcd_adj[j*4 +: 4] = bcd_q[j*4 +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
    end

    // Display formatting from the finished BCD value; only sampled on the COMMIT edge.
    always_comb begin
        for (int i = 0; i < int'(NDIG); i++) dig[i] = 4'd0;
        for (int j = 0; j < int'(BCD_N); j++) dig[j] = bcd_q[j*4 +: 4];
        usable = neg_q ? int'(DIGITS) - 1 : int'(DIGITS);
        ovf    = 1'b0;
        msd    = 0;
        for (int j = 0; j < int'(NDIG); j++) begin
            if (dig[j] != 4'd0) begin
                msd = j;
                if (j >= usable) ovf = 1'b1;
            end
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (ovf) begin
                disp_new[i] = (i == 2) ? 8'h79 : (i < 2) ? 8'h50 : 8'h00;
            end else if (i <= msd) begin
                disp_new[i] = seg7(dig[i]);
            end else if (neg_q && i == msd + 1) begin
                disp_new[i] = 8'h40;
            end else begin
                disp_new[i] = 8'h00;
            end
            disp_new[i][7] = dp_q[i];
        end
    end

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            mag_q  <= '0;
            neg_q  <= 1'b0;
            dp_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            disp_q <= {DIGITS{8'h40}};
        end else begin
            if (accept) begin
                mag_q <= mag_in;
                neg_q <= bus.fnd_serial[DATA_W-1];
                dp_q  <= bus.dp_mask;
                bcd_q <= '0;
                cnt_q <= '0;
            end else if (state_q == StConv) begin
                bcd_q <= bcd_next;
                mag_q <= {mag_q[DATA_W-2:0], 1'b0};
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == StCommit) disp_q <= disp_new;
        end
    end

    assign p_wrap = &p_q;
    assign k_wrap = p_wrap && (k_q == KLast);
    assign lit    = (p_q[DIV_LOG2-1 -: BRIGHT_W] <= brightness) && !(blink && frame_q[BLINK_LOG2]);

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            k_q     <= '0;
            frame_q <= '0;
            fnd_s_q <= '1;
            fnd_d_q <= 8'h00;
        end else begin
            p_q <= p_q + DIV_LOG2'(1);
            if (p_wrap) k_q <= k_wrap ? '0 : k_q + KW'(1);
            if (k_wrap) frame_q <= frame_q + FW'(1);
            fnd_s_q <= lit ? ~(DIGITS'(1) << k_q) : '1;
            fnd_d_q <= lit ? disp_q[k_q] : 8'h00;
        end
    end

    assign fnd_s = fnd_s_q;
    assign fnd_d = fnd_d_q;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: reset scan, conversion/format table, PWM, blink, aborts.
module tb_fnd_scan_driver;
    logic       clk;
    logic       rst;
    logic [2:0] brightness;
    logic       blink;
    logic [5:0] fnd_s;
    logic [7:0] fnd_d;

    int n_tests = 0;
    int n_fail  = 0;

    fnd_scan_driver_if #(.DIGITS(6), .DATA_W(32)) bus ();

    fnd_scan_driver #(
        .DIGITS(6), .DATA_W(32), .DIV_LOG2(4), .BRIGHT_W(3), .BLINK_LOG2(1)
    ) dut (
        .fnd_clk   (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .brightness(brightness),
        .blink     (blink),
        .fnd_s     (fnd_s),
        .fnd_d     (fnd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        logic [5:0]  dp;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives one load at a negedge and returns the number of busy cycles seen.
    // A second load (value 7) is pulsed mid-conversion and must be ignored.
    task automatic do_load(input logic [31:0] val, input logic [5:0] dp, output int cnt);
        int guard;
        @(negedge clk);
        bus.fnd_serial = val;
        bus.dp_mask    = dp;
        bus.load       = 1'b1;
        cnt   = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (bus.busy) cnt++;
            if (cnt == 1) bus.load = 1'b0;
            if (cnt == 5) begin
                bus.load       = 1'b1;
                bus.fnd_serial = 32'd7;
            end
            if (cnt == 6) bus.load = 1'b0;
        end while (bus.busy && guard < 200);
        bus.load = 1'b0;
    endtask

    // Collects one full scan (96 cycles) as {d5..d0}; digits never seen stay X.
    task automatic read_frame(output logic [47:0] got, output int bad_sel);
        got     = 'x;
        bad_sel = 0;
        repeat (96) begin
            @(negedge clk);
            if (fnd_s != 6'b111111) begin
                if ($countones(~fnd_s) != 1) bad_sel++;
                for (int i = 0; i < 6; i++) if (!fnd_s[i]) got[i*8 +: 8] = fnd_d;
            end
        end
    endtask

    task automatic count_lit(input int cycles, output int lit, output int bad_d,
                             input logic [7:0] exp_d);
        lit   = 0;
        bad_d = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (fnd_s != 6'b111111) begin
                lit++;
                if (fnd_d !== exp_d) bad_d++;
            end else if (fnd_d !== 8'h00) begin
                bad_d++;
            end
        end
    endtask

    initial begin
        logic [47:0] frame;
        int          cnt, bad, lit, guard;

        vecs[0]  = '{32'd42,          6'b000000, 48'h0000_0000_665B};
        vecs[1]  = '{-32'sd42,        6'b000010, 48'h0000_0040_E65B};
        vecs[2]  = '{32'd0,           6'b000000, 48'h0000_0000_003F};
        vecs[3]  = '{32'd999999,      6'b000000, 48'h6F6F_6F6F_6F6F};
        vecs[4]  = '{32'd1000000,     6'b000000, 48'h0000_0079_5050};
        vecs[5]  = '{-32'sd99999,     6'b000000, 48'h406F_6F6F_6F6F};
        vecs[6]  = '{-32'sd100000,    6'b000000, 48'h0000_0079_5050};
        vecs[7]  = '{32'h8000_0000,   6'b000000, 48'h0000_0079_5050};
        vecs[8]  = '{32'd1000000,     6'b100001, 48'h8000_0079_50D0};
        vecs[9]  = '{32'd123456,      6'b000000, 48'h065B_4F66_6D7D};
        vecs[10] = '{-32'sd7,         6'b000000, 48'h0000_0000_4007};
        vecs[11] = '{32'd0,           6'b111111, 48'h8080_8080_80BF};

        rst            = 1'b1;
        brightness     = 3'd7;
        blink          = 1'b0;
        bus.load       = 1'b0;
        bus.fnd_serial = '0;
        bus.dp_mask    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (37) @(negedge clk);

        // Reset asserted mid-scan.
        rst = 1'b1;
        #1;
        check("reset fnd_s", fnd_s, 6'b111111);
        check("reset fnd_d", fnd_d, 8'h00);
        check("reset busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("reset held fnd_s", fnd_s, 6'b111111);
        rst = 1'b0;

        for (int s = 0; s < 6; s++) begin
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (fnd_s !== ~(6'b1 << s) || fnd_d !== 8'h40) bad++;
            end
            check($sformatf("dash slot %0d bad samples", s), bad, 0);
        end

        foreach (vecs[i]) begin
            do_load(vecs[i].val, vecs[i].dp, cnt);
            check($sformatf("vec%0d busy cycles", i), cnt, 33);
            read_frame(frame, bad);
            check($sformatf("vec%0d frame", i), frame, vecs[i].exp);
            check($sformatf("vec%0d select one-hot", i), bad, 0);
        end

        // Load held across the COMMIT edge is accepted there; busy never drops.
        @(negedge clk);
        bus.fnd_serial = 32'd42;
        bus.dp_mask    = '0;
        bus.load       = 1'b1;
        cnt   = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (bus.busy) cnt++;
            if (cnt == 1) bus.fnd_serial = 32'd5;
            if (cnt == 34) bus.load = 1'b0;
        end while (bus.busy && guard < 200);
        bus.load = 1'b0;
        check("back-to-back busy cycles", cnt, 66);
        read_frame(frame, bad);
        check("back-to-back frame", frame, 48'h0000_0000_006D);

        brightness = 3'd0;
        @(negedge clk);
        count_lit(96, lit, bad, 8'hxx);
        check("brightness0 lit cycles", lit, 12);
        brightness = 3'd3;
        @(negedge clk);
        count_lit(96, lit, bad, 8'hxx);
        check("brightness3 lit cycles", lit, 48);
        brightness = 3'd7;
        @(negedge clk);
        count_lit(96, lit, bad, 8'hxx);
        check("brightness7 lit cycles", lit, 96);

        // Blink from a fresh frame counter: frames 0,1 lit, 2,3 dark; buffer back to dashes.
        rst   = 1'b1;
        blink = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_lit(192, lit, bad, 8'h40);
        check("blink lit phase", lit, 192);
        check("blink lit phase data", bad, 0);
        count_lit(192, lit, bad, 8'h40);
        check("blink dark phase", lit, 0);
        blink = 1'b0;

        // Reset 10 cycles into a conversion of 123 discards it.
        @(negedge clk);
        bus.fnd_serial = 32'd123;
        bus.dp_mask    = '0;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-conv busy before reset", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid-conv reset busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        read_frame(frame, bad);
        check("post-abort frame", frame, 48'h4040_4040_4040);
        check("post-abort busy", bus.busy, 1'b0);
        do_load(32'd5, 6'b000000, cnt);
        check("reload busy cycles", cnt, 33);
        read_frame(frame, bad);
        check("reload frame", frame, 48'h0000_0000_006D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
